uart_tx: RTL and testbench
==========================

# uart_tx

Oversampled UART transmitter, the transmit-side counterpart of the team's oversampled UART receiver. It shares the same `baud_sample_tick` generator (OVERSAMPLE ticks per bit) and serialises bytes LSB-first with start, optional parity, and stop bits. A one-entry holding register sits in front of the shift register, so a new byte can be accepted while the current frame is on the wire; frames then go out back-to-back with no idle gap.

## Interface
- OVERSAMPLE, 16: baud_sample_tick rising edges per bit period; power of two, ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_sample_tick  in  1  oversample tick; only its rising edge is used; may stay high for many clk cycles.
- tx_data  in  DATA_BITS  byte to send; sampled on accept.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register empty; accept occurs on a clk edge where tx_valid && tx_ready.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  high from start bit through end of last stop bit.
- tx_done  out  1  one-clk pulse at the end of each frame's last stop bit.

## Operation
- Edge detect:
  - tick_d is a register that resets to 1.
  - tick_en = baud_sample_tick & ~tick_d, combinational.
  - All bit timing advances only on clk edges where tick_en = 1.
- Holding register:
  - On accept, hold ← tx_data, hold_full ← 1, tx_ready ← 0.
  - A transfer to the shift register clears hold_full, and tx_ready ← 1 on the same edge.
  - tx_valid while tx_ready = 0 is ignored; tx_data is not captured.
- FSM states: IDLE, START, DATA, PARITY, STOP. tick_cnt counts 0..OVERSAMPLE-1, width $clog2(OVERSAMPLE).
- IDLE: tx = 1. On tick_en with hold_full, the state moves to START:
  - shift ← hold, tick_cnt ← 0, bit_cnt ← 0, parity accumulator cleared;
  - tx ← 0 and tx_busy ← 1.
- Each bit lasts exactly OVERSAMPLE tick_en events. On tick_en with tick_cnt = OVERSAMPLE-1, the bit ends and tick_cnt wraps to 0; otherwise tick_cnt increments.
- START → DATA: tx ← shift[0].
- DATA: at each bit end, shift right and bit_cnt++.
  - After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - The parity bit is XOR of data bits; it is inverted for odd parity, so the total count of 1s (data + parity) is odd.
- PARITY → STOP: tx ← 1.
- STOP: lasts STOP_BITS×OVERSAMPLE ticks. At its final tick, tx_done pulses.
  - If hold_full, go directly to START with the transfer above. There is no idle tick; tx_busy stays 1.
  - Otherwise go to IDLE, with tx_busy ← 0 and tx stays 1.
- Frame length is exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×OVERSAMPLE tick_en events.
- Reset (any time, including mid-frame):
  - tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0;
  - FSM goes to IDLE; hold_full, tick_cnt, bit_cnt, and shift are cleared; tick_d = 1.
  - The aborted frame produces no tx_done.

## Timing
- All outputs are registered. Reset values: tx 1, tx_ready 1, tx_busy 0, tx_done 0.
- Accept at edge N sets hold_full at N+1. The start bit begins at the first tick_en edge at or after N+1.
- Each tx transition occurs on the clk edge where tick_en is high at the bit boundary.
- tx_done is high for exactly one clk, on the edge that ends the last stop bit.
- tx_ready re-asserts on the edge of the transfer; earliest re-accept is that same edge +1.
- A tick held high for K clk cycles counts as one tick_en.

## Test plan
- 8N1, OVERSAMPLE=16, tick pulse every 4 clk, send 0xA5:
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 ticks (64 clk);
  - one tx_done pulse; tx_busy low afterwards.
- Back-to-back 0x00 then 0xFF, tx_valid held high:
  - second byte accepted while first is in flight;
  - second start bit immediately follows first stop bit (no idle tick);
  - tx_ready falls on each accept and rises on each transfer; two tx_done pulses.
- PARITY=2, DATA 0x07: parity bit 1. PARITY=1, same data: parity bit 0. STOP_BITS=2: stop high for 32 ticks before tx_done.
- baud_sample_tick held high for 10 clk per tick: each bit still spans exactly 16 ticks, not 160 clk-counted ticks.
- rst asserted mid data bit 3 of 0x3C:
  - tx = 1, tx_busy = 0, tx_ready = 1 immediately; no tx_done;
  - after release, 0x81 transmits correctly.
- tx_valid with changing tx_data while hold full: only the accepted value is transmitted; the rejected values never appear on tx.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Oversampled UART transmitter. Bit timing is driven by the rising edge of
// baud_sample_tick (OVERSAMPLE edges per bit), the same tick generator used by
// the matching oversampled receiver. Frames are sent LSB-first as
// start / DATA_BITS data / optional parity / STOP_BITS stop.
//
// A one-entry holding register sits in front of the shift register. A new byte
// can therefore be accepted while the current frame is still on the wire. When
// the holding register is full at the end of a stop bit, the next start bit
// follows immediately, with no idle tick in between.
//
// Parameters
//   OVERSAMPLE : tick edges per bit (power of two, >= 4)
//   DATA_BITS  : data bits per frame (5..8)
//   PARITY     : 0 none, 1 odd, 2 even
//   STOP_BITS  : 1 or 2
//
// Ports
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   baud_sample_tick in   oversample tick; only its rising edge counts
//   tx_data          in   byte to send, captured on accept
//   tx_valid         in   tx_data valid
//   tx_ready         out  holding register empty (accept = tx_valid & tx_ready)
//   tx               out  serial line, idle high
//   tx_busy          out  high from start bit through end of last stop bit
//   tx_done          out  one-clk pulse at the end of each frame's last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_sample_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q,     state_d;
    logic [CNT_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 par_q,       par_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_q,        tx_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 ready_q,     ready_d;

    // Previous tick level. Resets high so that a tick already high when reset
    // releases is not mistaken for a fresh rising edge.
    logic                 tick_prev_q;
    logic                 tick_en;

    logic                 accept;
    logic                 bit_end;
    logic                 load;

    assign tick_en = baud_sample_tick & ~tick_prev_q;
    assign accept  = tx_valid & ready_q;
    assign bit_end = tick_en && (tick_cnt_q == CNT_W'(OVERSAMPLE - 1));

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ready_d     = ready_q;
        load        = 1'b0;

        // The tick counter free-runs through every bit of an active frame.
        if (tick_en && (state_q != S_IDLE)) begin
            if (bit_end) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tick_en && hold_full_q) begin
                    load = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    // shift_q[0] is the bit that has just finished on the line.
                    par_d     = par_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            // Even: XOR of data. Odd: inverted so total 1s is odd.
                            tx_d    = par_q ^ shift_q[0] ^ 1'(PARITY == 1);
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            // Back-to-back: next start bit begins on this tick.
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Transfer holding register into the shift register and start a frame.
        if (load) begin
            state_d     = S_START;
            shift_d     = hold_q;
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            par_d       = 1'b0;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
            hold_full_d = 1'b0;
            ready_d     = 1'b1;
        end

        // ready_q mirrors ~hold_full_q, so accept and load never coincide.
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
            ready_d     = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            tick_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            tick_prev_q <= baud_sample_tick;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Four uart_tx instances share clk, rst and the tick:
//   0: 8N1   1: 8E1   2: 8O1   3: 8N2
// A monitor decodes each tx line at every tick rising edge into frames
// (16 samples per bit, all samples of a bit must agree) and records where
// each tx_done pulse lands. Expected frames are queued when a byte is driven
// and compared when the monitor delivers a decoded frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NI = 4;
    localparam int OS = 16;

    typedef struct {
        int          start_evt;
        logic [15:0] bits;
        bit          glitch;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [7:0]    tx_data [NI];
    logic [NI-1:0] tx_valid = '0;
    logic [NI-1:0] tx_ready_w;
    logic [NI-1:0] tx_w;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;

    int total = 0;
    int bad   = 0;

    int tick_hi = 1;
    int tick_lo = 3;

    // Bench-side tick edge detector and running tick-event index.
    bit tp      = 1'b1;
    bit ev_r    = 1'b0;
    int evt_cnt = 0;

    // Monitor-owned state and outputs.
    frame_t obs_q     [NI][$];
    bit     done_ok_q [NI][$];
    int     done_cyc  [NI] = '{default: 0};
    bit     in_f      [NI] = '{default: 1'b0};
    int     idx       [NI] = '{default: 0};
    frame_t cur       [NI];
    int     last_end  [NI] = '{default: -10};

    // Main-block-owned scoreboard state.
    logic [15:0] exp_q [NI][$];
    int          rd    [NI] = '{default: 0};
    int          drd   [NI] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        uart_tx #(
            .OVERSAMPLE(OS),
            .DATA_BITS (8),
            .PARITY    (gi == 1 ? 2 : (gi == 2 ? 1 : 0)),
            .STOP_BITS (gi == 3 ? 2 : 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .baud_sample_tick(tick),
            .tx_data         (tx_data[gi]),
            .tx_valid        (tx_valid[gi]),
            .tx_ready        (tx_ready_w[gi]),
            .tx              (tx_w[gi]),
            .tx_busy         (busy_w[gi]),
            .tx_done         (done_w[gi])
        );
    end

    function automatic int flen(input int i);
        return 1 + 8 + ((i == 1 || i == 2) ? 1 : 0) + ((i == 3) ? 2 : 1);
    endfunction

    function automatic logic [15:0] mk_frame(input int i, input logic [7:0] d);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (i == 1) f[9] = ^d;
        else if (i == 2) f[9] = ~(^d);
        return f;
    endfunction

    // Tick generator: tick_lo clocks low, tick_hi clocks high.
    initial begin
        forever begin
            repeat (tick_lo) @(negedge clk);
            tick = 1'b1;
            repeat (tick_hi) @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            tp   <= 1'b1;
            ev_r <= 1'b0;
        end else begin
            ev_r <= tick & ~tp;
            tp   <= tick;
            if (tick & ~tp) evt_cnt <= evt_cnt + 1;
        end
    end

    // Frame decoder / tx_done position monitor.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                in_f[i] = 1'b0;
            end else begin
                if (done_w[i]) begin
                    done_cyc[i] = done_cyc[i] + 1;
                    done_ok_q[i].push_back(ev_r && (evt_cnt == last_end[i] + 1));
                end
                if (ev_r) begin
                    if (!in_f[i] && tx_w[i] == 1'b0) begin
                        in_f[i]          = 1'b1;
                        idx[i]           = 0;
                        cur[i].start_evt = evt_cnt;
                        cur[i].bits      = '1;
                        cur[i].glitch    = 1'b0;
                    end
                    if (in_f[i]) begin
                        if (idx[i] % OS == 0) cur[i].bits[idx[i] / OS] = tx_w[i];
                        else if (cur[i].bits[idx[i] / OS] !== tx_w[i]) cur[i].glitch = 1'b1;
                        idx[i] = idx[i] + 1;
                        if (idx[i] == flen(i) * OS) begin
                            obs_q[i].push_back(cur[i]);
                            in_f[i]     = 1'b0;
                            last_end[i] = evt_cnt;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic wait_ready(input int i, input int budget, input string tag);
        int k = 0;
        while (!tx_ready_w[i] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_ready_w[i]), 32'd1);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        wait_ready(i, 4000, "send_ready");
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        exp_q[i].push_back(mk_frame(i, d));
        @(posedge clk);
        #1;
        tx_valid[i] = 1'b0;
        chk("accept_ready_low", 32'(tx_ready_w[i]), 32'd0);
        $display("send inst=%0d data=%02h", i, d);
    endtask

    task automatic next_frame(input int i, input string tag, output frame_t f);
        int          k = 0;
        logic [15:0] e;
        while (obs_q[i].size() <= rd[i] && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (obs_q[i].size() > rd[i]) begin
            f = obs_q[i][rd[i]];
            rd[i]++;
        end else begin
            f.bits      = '0;
            f.glitch    = 1'b1;
            f.start_evt = -1;
        end
        e = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 16'hDEAD;
        chk({tag, "_bits"}, 32'(f.bits), 32'(e));
        chk({tag, "_bitlen"}, 32'(f.glitch), 32'd0);
        $display("frame inst=%0d tag=%s bits=%04h start_evt=%0d", i, tag, f.bits, f.start_evt);
    endtask

    task automatic wait_done(input int i, input string tag);
        int k  = 0;
        bit ok = 1'b0;
        while (done_ok_q[i].size() <= drd[i] && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (done_ok_q[i].size() > drd[i]) begin
            ok = done_ok_q[i][drd[i]];
            drd[i]++;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        frame_t f0;
        frame_t f1;
        int     k;
        int     e0;
        int     dcnt;
        logic [7:0] d;

        for (int i = 0; i < NI; i++) tx_data[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx_w[0]),       32'd1);
        chk("rst_ready", 32'(tx_ready_w[0]), 32'd1);
        chk("rst_busy",  32'(busy_w[0]),     32'd0);
        chk("rst_done",  32'(done_w[3]),     32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1, 0xA5
        send(0, 8'hA5);
        k = 0;
        while (tx_w[0] && k < 100) begin @(negedge clk); k++; end
        chk("a5_busy_mid", 32'(busy_w[0]), 32'd1);
        next_frame(0, "a5", f0);
        wait_done(0, "a5_done_pos");
        repeat (3) @(negedge clk);
        chk("a5_busy_after", 32'(busy_w[0]), 32'd0);
        chk("a5_tx_idle",    32'(tx_w[0]),   32'd1);
        chk("a5_done_cnt",   32'(done_cyc[0]), 32'd1);

        // Back-to-back 0x00 then 0xFF with tx_valid held high
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        exp_q[0].push_back(mk_frame(0, 8'h00));
        @(posedge clk);
        #1;
        chk("b2b_acc0_ready", 32'(tx_ready_w[0]), 32'd0);
        tx_data[0] = 8'hFF;
        wait_ready(0, 100, "b2b_xfer0");
        chk("b2b_xfer0_tx",   32'(tx_w[0]),   32'd0);
        chk("b2b_xfer0_busy", 32'(busy_w[0]), 32'd1);
        exp_q[0].push_back(mk_frame(0, 8'hFF));
        @(posedge clk);
        #1;
        chk("b2b_acc1_ready", 32'(tx_ready_w[0]), 32'd0);
        tx_valid[0] = 1'b0;
        wait_ready(0, 3000, "b2b_xfer1");
        chk("b2b_xfer1_tx",   32'(tx_w[0]),   32'd0);
        chk("b2b_xfer1_busy", 32'(busy_w[0]), 32'd1);
        next_frame(0, "b2b_00", f0);
        next_frame(0, "b2b_ff", f1);
        chk("b2b_no_gap", 32'(f1.start_evt - f0.start_evt), 32'(flen(0) * OS));
        wait_done(0, "b2b_done0_pos");
        wait_done(0, "b2b_done1_pos");
        repeat (3) @(negedge clk);
        chk("b2b_done_cnt", 32'(done_cyc[0]), 32'd3);

        // Parity and two stop bits
        send(1, 8'h07);
        send(2, 8'h07);
        send(3, 8'h5A);
        next_frame(1, "even_07", f0);
        chk("even_par_bit", 32'(f0.bits[9]), 32'd1);
        next_frame(2, "odd_07", f0);
        chk("odd_par_bit", 32'(f0.bits[9]), 32'd0);
        next_frame(3, "stop2_5a", f0);
        wait_done(1, "even_done_pos");
        wait_done(2, "odd_done_pos");
        wait_done(3, "stop2_done_pos");

        // Tick held high 10 clk per tick
        tick_hi = 10;
        tick_lo = 2;
        send(0, 8'hC3);
        next_frame(0, "held_c3", f0);
        wait_done(0, "held_done_pos");
        tick_hi = 1;
        tick_lo = 3;
        repeat (30) @(negedge clk);

        // Reset in the middle of data bit 3 of 0x3C
        send(0, 8'h3C);
        k = 0;
        while (tx_w[0] && k < 100) begin @(negedge clk); k++; end
        e0 = evt_cnt;
        k  = 0;
        while (evt_cnt < e0 + 4 * OS + 8 && k < 2000) begin @(negedge clk); k++; end
        dcnt = done_cyc[0];
        rst  = 1'b1;
        #1;
        chk("abort_tx",    32'(tx_w[0]),       32'd1);
        chk("abort_busy",  32'(busy_w[0]),     32'd0);
        chk("abort_ready", 32'(tx_ready_w[0]), 32'd1);
        chk("abort_done",  32'(done_w[0]),     32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        if (exp_q[0].size() > 0) void'(exp_q[0].pop_back());
        $display("reset inst=0 aborted frame 3c");
        repeat (5) @(negedge clk);
        send(0, 8'h81);
        next_frame(0, "post_rst_81", f0);
        wait_done(0, "post_rst_done_pos");
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cyc[0]), 32'(dcnt + 1));

        // Changing tx_data while the holding register is full
        send(0, 8'h12);
        wait_ready(0, 100, "hold_xfer");
        send(0, 8'h34);
        for (int c = 0; c < 60; c++) begin
            d = 8'($urandom_range(0, 255));
            if (d == 8'h34) d = 8'hE7;
            tx_data[0]  = d;
            tx_valid[0] = 1'b1;
            @(negedge clk);
        end
        chk("hold_blocked_ready", 32'(tx_ready_w[0]), 32'd0);
        tx_valid[0] = 1'b0;
        next_frame(0, "hold_12", f0);
        next_frame(0, "hold_34", f1);
        wait_done(0, "hold_done0_pos");
        wait_done(0, "hold_done1_pos");
        repeat (200) @(negedge clk);
        chk("hold_no_extra", 32'(obs_q[0].size() - rd[0]), 32'd0);
        chk("hold_idle_busy", 32'(busy_w[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
